// File: rtl/and3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : and3_rr_arbiter (with and3_datapath)
// Description : Round-robin shares one 3-input AND datapath among NUM_REQ
//               requesters; registered, id-tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================

module and3_datapath #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);
    assign y = a & b & c;
endmodule

module and3_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_c,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [CNT_W-1:0]         done_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic              found;
    logic              can_accept;
    logic              accept;
    logic              rsp_hs;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  sel_c;
    logic [WIDTH-1:0]  and_y;

    // Two passes: lanes at or above ptr first, then wrap to the lower lanes.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    assign rsp_valid  = (state == RESP);
    assign can_accept = rst_n && ((state == IDLE) || rsp_ready);
    assign accept     = found && can_accept;
    assign rsp_hs     = rsp_valid && rsp_ready;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_c     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (win == ID_W'(i));
            if (win == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    and3_datapath #(
        .WIDTH (WIDTH)
    ) u_and3 (
        .a (sel_a),
        .b (sel_b),
        .c (sel_c),
        .y (and_y)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESP;
            RESP:    if (rsp_hs && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            done_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rsp_data <= and_y;
                rsp_id   <= win;
                ptr      <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
            end
            if (rsp_hs) begin
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_and3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_and3_rr_arbiter
// Description : Directed bench for and3_rr_arbiter (CNT_W=4 to reach wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and3_rr_arbiter;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*WIDTH-1:0] req_c;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic [CNT_W-1:0]         done_count;

    int vectors = 0;
    int errs    = 0;

    and3_rr_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lane_res [3];

    initial begin
        int lane;
        logic [7:0] ra, rb, rc;

        // lane0: AA&F0&CF=80, lane1: F0&3C&FF=30, lane2: 5F&7E&3B=1A
        req_a = {8'h5F, 8'hF0, 8'hAA};
        req_b = {8'h7E, 8'h3C, 8'hF0};
        req_c = {8'h3B, 8'hFF, 8'hCF};
        lane_res[0] = 8'h80;
        lane_res[1] = 8'h30;
        lane_res[2] = 8'h1A;

        // Reset: req_ready must stay low even with every lane requesting
        rst_n = 1'b0; req_valid = 3'b111; rsp_ready = 1'b1;
        #1 chk("rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_done", 32'(done_count), 32'h0);
        rst_n = 1'b1; req_valid = 3'b000;
        tick();

        // Single lane 1
        req_valid = 3'b010;
        #1 chk("t1_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 3'b000;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", 32'(rsp_data), 32'h30);
        chk("t1_rsp_id", 32'(rsp_id), 32'h1);
        tick();
        chk("t1_done", 32'(done_count), 32'h1);
        chk("t1_idle", 32'(rsp_valid), 32'h0);

        // ptr=2, only lane 0 valid -> wrap grant, ptr becomes 1
        req_valid = 3'b001;
        #1 chk("t4_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t4_rsp_id", 32'(rsp_id), 32'h0);
        chk("t4_rsp_data", 32'(rsp_data), 32'h80);
        req_valid = 3'b011;
        #1 chk("t4_ptr1_req_ready", 32'(req_ready), 32'h2);
        tick();
        chk("t4_ptr1_rsp_id", 32'(rsp_id), 32'h1);
        chk("t4_ptr1_done", 32'(done_count), 32'h2);

        // Reset while a response is held under backpressure
        rsp_ready = 1'b0; req_valid = 3'b000;
        #1 chk("t5_stall_req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_done", 32'(done_count), 32'h0);
        req_valid = 3'b111; rsp_ready = 1'b1;
        #1 chk("t5_prio_lane0", 32'(req_ready), 32'h1);

        // All lanes valid: 0,1,2,0,1,2 back to back
        for (int k = 0; k < 6; k++) begin
            chk("t2_req_ready", 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("t2_rsp_id", 32'(rsp_id), 32'(k % 3));
            chk("t2_rsp_data", 32'(rsp_data), 32'(lane_res[k % 3]));
            chk("t2_done", 32'(done_count), 32'(k));
        end
        req_valid = 3'b000;
        tick();
        chk("t2_done6", 32'(done_count), 32'h6);
        chk("t2_idle", 32'(rsp_valid), 32'h0);

        // Backpressure with lanes 0 and 2 valid (ptr=0)
        req_valid = 3'b101;
        #1 chk("t3_req_ready", 32'(req_ready), 32'h1);
        tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_stall_req_ready", 32'(req_ready), 32'h0);
            chk("t3_stall_valid", 32'(rsp_valid), 32'h1);
            chk("t3_stall_id", 32'(rsp_id), 32'h0);
            chk("t3_stall_data", 32'(rsp_data), 32'h80);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("t3_release_req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("t3_rsp_id", 32'(rsp_id), 32'h2);
        chk("t3_rsp_data", 32'(rsp_data), 32'h1A);
        chk("t3_done", 32'(done_count), 32'h7);
        req_valid = 3'b000;
        tick();
        chk("t3_done8", 32'(done_count), 32'h8);

        // Counter wrap with random single-lane operands
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            lane = int'($urandom_range(0, 2));
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            req_a[lane*WIDTH +: WIDTH] = ra;
            req_b[lane*WIDTH +: WIDTH] = rb;
            req_c[lane*WIDTH +: WIDTH] = rc;
            req_valid = 3'(1 << lane);
            #1 chk("t6_req_ready", 32'(req_ready), 32'(1 << lane));
            tick();
            req_valid = 3'b000;
            chk("t6_rsp_id", 32'(rsp_id), 32'(lane));
            chk("t6_rsp_data", 32'(rsp_data), 32'(ra & rb & rc));
        end
        tick();
        chk("t6_done_wrap", 32'(done_count), 32'h1);
        chk("t6_idle", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
